// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at issue and held in pending registers until the latency expires.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic        we_hilo,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_hazard
);

  // state | meaning
  // IDLE  | no operation in flight; accepts start and mthi/mtlo
  // RUN   | counting down latency; pending result committed on terminal count

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W_RAW  = $clog2(MAX_CYCLES + 1);
  localparam int CNT_W      = (CNT_W_RAW < 4) ? 4 : CNT_W_RAW;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n;
  logic [31:0]      hi_n, lo_n;
  logic [31:0]      hi_p, lo_p, hi_p_n, lo_p_n;
  logic             commit, commit_n;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0]        q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic               b_zero;
  logic [31:0]        res_hi, res_lo;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes so that 0x80000000 / -1 wraps to 0x80000000
  // instead of relying on simulator overflow behaviour.
  assign b_zero     = (b == 32'd0);
  assign a_mag      = a[31] ? (~a + 32'd1) : a;
  assign b_mag      = b[31] ? (~b + 32'd1) : b;
  assign b_mag_safe = b_zero ? 32'd1 : b_mag;
  assign b_safe     = b_zero ? 32'd1 : b;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;
  assign q_s        = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s        = a[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u        = a / b_safe;
  assign r_u        = a % b_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (mdu_op)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
      OP_DIVU:  begin res_hi = r_u;           res_lo = q_u;          end
      default:  begin res_hi = 32'd0;         res_lo = 32'd0;        end
    endcase
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    busy_n   = busy;
    hi_n     = hi;
    lo_n     = lo;
    hi_p_n   = hi_p;
    lo_p_n   = lo_p;
    commit_n = commit;
    case (state)
      IDLE: begin
        if (start && !mdu_op[2]) begin
          hi_p_n   = res_hi;
          lo_p_n   = res_lo;
          commit_n = !(mdu_op[1] && b_zero);
          cnt_n    = mdu_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          busy_n   = 1'b1;
          state_n  = RUN;
        end else if (!start && we_hilo) begin
          if (mdu_op == OP_MTHI) hi_n = a;
          else if (mdu_op == OP_MTLO) lo_n = a;
        end
      end
      RUN: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          if (commit) begin
            hi_n = hi_p;
            lo_n = lo_p;
          end
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      hi_p   <= 32'd0;
      lo_p   <= 32'd0;
      commit <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      busy   <= busy_n;
      hi     <= hi_n;
      lo     <= lo_n;
      hi_p   <= hi_p_n;
      lo_p   <= lo_p_n;
      commit <= commit_n;
    end
  end

  assign md_hazard = start | busy;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, results, HI/LO moves,
// divide-by-zero suppression, ignored requests and asynchronous reset.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdu_op = 3'd7;
  logic        we_hilo = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, md_hazard;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .we_hilo(we_hilo),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .md_hazard(md_hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation in the current cycle and follow it to commit.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input int n,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] new_hi, input logic [31:0] new_lo);
    start = 1'b1; mdu_op = op; a = va; b = vb;
    #1;
    chk({tag, " hazard_at_start"}, {31'd0, md_hazard}, 32'd1);
    chk({tag, " busy_at_start"}, {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0; mdu_op = 3'd7; a = 32'd0; b = 32'd0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk($sformatf("%s busy_c%0d", tag, i), {31'd0, busy}, 32'd1);
      chk($sformatf("%s hazard_c%0d", tag, i), {31'd0, md_hazard}, 32'd1);
      chk($sformatf("%s hi_hold_c%0d", tag, i), hi, old_hi);
      chk($sformatf("%s lo_hold_c%0d", tag, i), lo, old_lo);
      tick();
    end
    chk({tag, " busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, " hazard_done"}, {31'd0, md_hazard}, 32'd0);
    chk({tag, " hi"}, hi, new_hi);
    chk({tag, " lo"}, lo, new_lo);
  endtask

  initial begin
    #12;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_hazard", {31'd0, md_hazard}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, MC, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    // Back-to-back: next start issued in the cycle busy has just fallen.
    run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, MC, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00000002, 32'hFFFFFFFA);
    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, DC, 32'h00000002, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 3'd3, 32'd7, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd3);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, DC, 32'd1, 32'd3, 32'd0, 32'h80000000);
    run_op("div_pos", 3'd2, 32'd100, 32'hFFFFFFF9, DC, 32'd0, 32'h80000000, 32'd2, 32'hFFFFFFF2);

    we_hilo = 1'b1; mdu_op = 3'd4; a = 32'h11;
    tick();
    mdu_op = 3'd5; a = 32'h22;
    tick();
    we_hilo = 1'b0; mdu_op = 3'd7; a = 32'd0;
    chk("preload_hi", hi, 32'h11);
    chk("preload_lo", lo, 32'h22);
    run_op("div0", 3'd2, 32'd55, 32'd0, DC, 32'h11, 32'h22, 32'h11, 32'h22);
    run_op("divu0", 3'd3, 32'd55, 32'd0, DC, 32'h11, 32'h22, 32'h11, 32'h22);

    we_hilo = 1'b1; mdu_op = 3'd4; a = 32'hDEADBEEF;
    tick();
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_lo", lo, 32'h22);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    mdu_op = 3'd5; a = 32'h12345678;
    tick();
    we_hilo = 1'b0; mdu_op = 3'd7; a = 32'd0;
    chk("mtlo_lo", lo, 32'h12345678);
    chk("mtlo_hi", hi, 32'hDEADBEEF);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    start = 1'b1; mdu_op = 3'd6; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    chk("op6_busy", {31'd0, busy}, 32'd0);
    chk("op6_lo", lo, 32'h12345678);
    // start with an mthi opcode must not write HI even with we_hilo asserted.
    start = 1'b1; we_hilo = 1'b1; mdu_op = 3'd4; a = 32'hCAFEF00D;
    tick();
    start = 1'b0; we_hilo = 1'b0; mdu_op = 3'd7;
    chk("start_wins_hi", hi, 32'hDEADBEEF);
    chk("start_wins_busy", {31'd0, busy}, 32'd0);

    start = 1'b1; mdu_op = 3'd0; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0; we_hilo = 1'b1; mdu_op = 3'd5; a = 32'hAAAAAAAA;
    tick();
    we_hilo = 1'b0; mdu_op = 3'd7; a = 32'd0;
    chk("mtlo_in_run_lo", lo, 32'h12345678);
    chk("mtlo_in_run_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < MC - 1; i++) tick();
    chk("mtlo_in_run_done", {31'd0, busy}, 32'd0);
    chk("mtlo_in_run_hi", hi, 32'd0);
    chk("mtlo_in_run_commit", lo, 32'd12);

    start = 1'b1; mdu_op = 3'd3; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0; mdu_op = 3'd7;
    tick();
    tick();
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DC + 3; i++) tick();
    chk("rst_after_busy", {31'd0, busy}, 32'd0);
    chk("rst_after_hi", hi, 32'd0);
    chk("rst_after_lo", lo, 32'd0);

    run_op("post_rst_mult", 3'd0, 32'h00010000, 32'h00010000, MC, 32'd0, 32'd0, 32'd1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
